// File: rtl/if_stage_if.sv
// Fetch-stage bus: the instruction-memory port, hazard/redirect controls and the IF/ID register outputs.
// The master modport is the fetch stage's view; slave is the surrounding pipeline/memory view.
interface if_stage_if #(
  parameter int unsigned PC_WIDTH_LENGTH   = 32,
  parameter int unsigned INST_WIDTH_LENGTH = 32
);
  localparam int unsigned CNT_WIDTH = 32;

  logic [PC_WIDTH_LENGTH-1:0]   imem_pc;
  logic [INST_WIDTH_LENGTH-1:0] imem_inst;
  logic                         stall;
  logic                         redirect;
  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc;
  logic [INST_WIDTH_LENGTH-1:0] ifid_inst;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc4;
  logic                         ifid_valid;
  logic                         misalign_err;
  logic [CNT_WIDTH-1:0]         fetch_cnt;

  modport master (
    output imem_pc, ifid_inst, ifid_pc, ifid_pc4, ifid_valid, misalign_err, fetch_cnt,
    input  imem_inst, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_pc, ifid_inst, ifid_pc, ifid_pc4, ifid_valid, misalign_err, fetch_cnt,
    output imem_inst, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register, and handles stalls,
// EX redirects and the halt that follows a misaligned redirect target.
module if_stage #(
  parameter int unsigned                  PC_WIDTH_LENGTH   = 32,
  parameter int unsigned                  INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = '0,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST          = INST_WIDTH_LENGTH'(32'h0000_0013)
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                       state;
  logic [PC_WIDTH_LENGTH-1:0]   pc_q;
  logic [PC_WIDTH_LENGTH-1:0]   pc_plus4;
  logic [INST_WIDTH_LENGTH-1:0] ifid_inst_q;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc_q;
  logic [PC_WIDTH_LENGTH-1:0]   ifid_pc4_q;
  logic                         ifid_valid_q;
  logic                         misalign_q;
  logic [CNT_WIDTH-1:0]         fetch_cnt_q;
  logic                         target_misaligned;

  assign pc_plus4          = pc_q + PC_WIDTH_LENGTH'(4);
  assign target_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Priority: reset, redirect, halt hold, stall hold, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc_q         <= RESET_PC;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else if (bus.redirect) begin
      pc_q         <= bus.redirect_pc;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      misalign_q   <= target_misaligned;
      state        <= target_misaligned ? HALT : RUN;
    end else if (state == HALT) begin
      // imem_inst is never sampled here, so a floating bus at a misaligned PC stays out of ID.
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q         <= pc_plus4;
      ifid_inst_q  <= bus.imem_inst;
      ifid_pc_q    <= pc_q;
      ifid_pc4_q   <= pc_plus4;
      ifid_valid_q <= 1'b1;
      fetch_cnt_q  <= fetch_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.imem_pc      = pc_q;
  assign bus.ifid_inst    = ifid_inst_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_pc4     = ifid_pc4_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_cnt    = fetch_cnt_q;
endmodule
